seven_seg_scan_driver: RTL

- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Holds a packed BCD/hex value, scans one digit per slot, and drives active-low segments, decimal point and anodes.
- Adds hex glyphs, leading-zero blanking, anti-ghosting blanking and tear-free double-buffered updates at frame boundaries.
- Sits between status/result registers and the board display pins.

---
 rtl/seven_seg_scan_driver_pkg.sv | 35 +++
 rtl/seven_seg_scan_driver_seg7_glyph.sv | 34 +++
 rtl/seven_seg_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph patterns
// and segment bit positions (bit0 = a ... bit6 = g).
package seven_seg_scan_driver_pkg;

  localparam int SEG_W = 7;
  localparam int NIBBLE_W = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Patterns are written g..a, so a 0 bit lights that segment.
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_scan_driver_seg7_glyph.sv
// Combinational nibble-to-glyph decoder; nibbles 10-15 show hex letters only
// when hex_en is set, otherwise they decode to a dark digit.
module seg7_glyph
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                hex_en,
  output logic [SEG_W-1:0]    pattern
);

  always_comb begin
    pattern = GLYPH_BLANK;
    case (nibble)
      4'h0: pattern = GLYPH_0;
      4'h1: pattern = GLYPH_1;
      4'h2: pattern = GLYPH_2;
      4'h3: pattern = GLYPH_3;
      4'h4: pattern = GLYPH_4;
      4'h5: pattern = GLYPH_5;
      4'h6: pattern = GLYPH_6;
      4'h7: pattern = GLYPH_7;
      4'h8: pattern = GLYPH_8;
      4'h9: pattern = GLYPH_9;
      4'hA: pattern = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: pattern = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: pattern = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: pattern = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: pattern = hex_en ? GLYPH_E : GLYPH_BLANK;
      4'hF: pattern = hex_en ? GLYPH_F : GLYPH_BLANK;
      default: pattern = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered value,
// hex glyphs, leading-zero blanking and a per-slot anti-ghosting blank window.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 2
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic [SEG_W-1:0]        seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      prescaler;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      disp_value;
  logic [VAL_W-1:0]      pend_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending;

  logic                  tick;
  logic                  boundary;
  logic                  in_blank;
  logic [NIBBLE_W-1:0]   sel_nibble;
  logic                  sel_dp;
  logic                  lz_blank;
  logic [SEG_W-1:0]      glyph;
  logic [NUM_DIGITS-1:0] an_next;

  always_comb begin
    tick     = (prescaler == PRE_LAST);
    boundary = tick && (idx == IDX_LAST);
    in_blank = (prescaler < PRE_BLANK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the pending buffer so it cannot be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_value <= '0;
      disp_dp    <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
    end else if (load && boundary) begin
      disp_value <= value_in;
      disp_dp    <= dp_in;
      pending    <= 1'b0;
    end else if (load) begin
      pend_value <= value_in;
      pend_dp    <= dp_in;
      pending    <= 1'b1;
    end else if (boundary && pending) begin
      disp_value <= pend_value;
      disp_dp    <= pend_dp;
      pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= boundary;
  end

  assign update_pending = pending;

  // Shifting the whole value down by the digit position leaves only this digit
  // and the ones above it, so a zero result means every higher nibble is zero.
  always_comb begin
    sel_nibble = NIBBLE_W'(disp_value >> {idx, 2'b00});
    sel_dp     = disp_dp[idx];
    lz_blank   = blank_lz && (idx != '0) && ((disp_value >> {idx, 2'b00}) == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = (idx != IDX_W'(i));
    end
  end

  seg7_glyph u_glyph (
    .nibble  (sel_nibble),
    .hex_en  (hex_en),
    .pattern (glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= GLYPH_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else if (in_blank) begin
      seg_n <= GLYPH_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= lz_blank ? GLYPH_BLANK : glyph;
      dp_n  <= ~sel_dp;
      an_n  <= an_next;
    end
  end

endmodule
